// File: rtl/decoder_pkg.sv
// decoder_pkg: RV32 opcodes, immediate formats, held-bundle layout
// and per-opcode lookups shared by the decode stage.
package decoder_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_MADD   = 7'b1000011;
  localparam logic [6:0] OPC_MSUB   = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB  = 7'b1001011;
  localparam logic [6:0] OPC_NMADD  = 7'b1001111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] rs3;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       int_we;
    logic       r4;
    logic       illegal;
  } dec_t;

  function automatic logic is_base_op(input logic [6:0] opc);
    logic r;
    unique case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_SYSTEM: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_r4_op(input logic [6:0] opc);
    logic r;
    unique case (opc)
      OPC_MADD, OPC_MSUB,
      OPC_NMSUB, OPC_NMADD: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic int_we_op(input logic [6:0] opc);
    logic r;
    unique case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OP_IMM, OPC_OP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    logic r;
    unique case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_SYSTEM: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    logic r;
    unique case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    imm_fmt_e r;
    unique case (opc)
      OPC_JALR, OPC_LOAD,
      OPC_OP_IMM, OPC_SYSTEM: r = IMM_I;
      OPC_STORE:              r = IMM_S;
      OPC_BRANCH:             r = IMM_B;
      OPC_LUI, OPC_AUIPC:     r = IMM_U;
      OPC_JAL:                r = IMM_J;
      default:                r = IMM_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: RV32 immediate assembly for I/S/B/U/J formats,
// sign-extended to XLEN.
module imm_gen
  import decoder_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;
  logic [31:0] i;

  assign i = {instr_i, 7'b0};

  always_comb begin
    imm32 = '0;
    unique case (fmt_i)
      IMM_I: imm32 = {{20{i[31]}}, i[31:20]};
      IMM_S: imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: imm32 = {{19{i[31]}}, i[31], i[7],
                      i[30:25], i[11:8], 1'b0};
      IMM_U: imm32 = {i[31:12], 12'b0};
      IMM_J: imm32 = {{11{i[31]}}, i[31], i[19:12],
                      i[20], i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decode with RAW/WAW scoreboard.
// DECODE_R4_EN adds MADD/MSUB/NMSUB/NMADD decode.
module decode_stage
  import decoder_pkg::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs3,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_int_we,
  output logic            out_r4,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic            flush
);

  localparam logic [5:0] NREG_W = 6'(NREG);
  localparam logic [NREG-1:0] ONE =
    {{(NREG-1){1'b0}}, 1'b1};

  logic [6:0] opc;
  logic [4:0] rs1, rs2, rd;
  logic r4, use1, use2, we_op;
  logic bad_reg, illegal, we_eff;
  logic hazard, accept;
  imm_fmt_e fmt;
  logic [XLEN-1:0] imm;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] busy_eff, wb_mask;
  logic valid_q;
  dec_t dec_q, dec_d;
  logic [XLEN-1:0] imm_q;

  assign opc = in_instr[6:0];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

`ifdef DECODE_R4_EN
  assign r4 = is_r4_op(opc);
`else
  assign r4 = 1'b0;
`endif

  assign use1  = uses_rs1(opc);
  assign use2  = uses_rs2(opc);
  assign we_op = int_we_op(opc);

  // Shift-based lookup: indices past NREG read as not busy.
  function automatic logic hit(
    input logic [NREG-1:0] v,
    input logic [4:0]      idx
  );
    return |(v & (ONE << idx));
  endfunction

  assign wb_mask  = wb_valid ? (ONE << wb_addr) : '0;
  assign busy_eff = busy_q & ~wb_mask;

  assign hazard = (use1  && hit(busy_eff, rs1))
               || (use2  && hit(busy_eff, rs2))
               || (we_op && hit(busy_eff, rd));

  assign bad_reg = (use1  && {1'b0, rs1} >= NREG_W)
                || (use2  && {1'b0, rs2} >= NREG_W)
                || (we_op && {1'b0, rd}  >= NREG_W);

  assign illegal = !(is_base_op(opc) || r4) || bad_reg;
  assign we_eff  = we_op && !illegal && (rd != 5'd0);
  assign fmt     = r4 ? IMM_NONE : imm_fmt(opc);

  assign in_ready = reset && (!valid_q || out_ready)
                 && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .instr_i (in_instr[31:7]),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  always_comb begin
    dec_d         = '0;
    dec_d.rs1     = rs1;
    dec_d.rs2     = rs2;
    dec_d.rd      = rd;
    dec_d.rs3     = in_instr[31:27];
    dec_d.opcode  = opc;
    dec_d.funct3  = in_instr[14:12];
    dec_d.funct7  = in_instr[31:25];
    dec_d.int_we  = we_eff;
    dec_d.r4      = r4;
    dec_d.illegal = illegal;
  end

  // Set after clear so a same-cycle writeback loses.
  always_comb begin
    busy_d = busy_eff;
    if (accept && we_eff) busy_d = busy_d | (ONE << rd);
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      imm_q   <= '0;
      busy_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept) begin
        dec_q <= dec_d;
        imm_q <= imm;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_rs1     = dec_q.rs1;
  assign out_rs2     = dec_q.rs2;
  assign out_rd      = dec_q.rd;
  assign out_rs3     = dec_q.rs3;
  assign out_opcode  = dec_q.opcode;
  assign out_funct3  = dec_q.funct3;
  assign out_funct7  = dec_q.funct7;
  assign out_imm     = imm_q;
  assign out_int_we  = dec_q.int_we;
  assign out_r4      = dec_q.r4;
  assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage
// against a behavioural decode/scoreboard model.
module tb_decode_stage;

  localparam int XLEN = 32;
`ifdef DECODE_R4_EN
  localparam bit R4_EN = 1'b1;
`else
  localparam bit R4_EN = 1'b0;
`endif

  localparam logic [6:0] OPS [15] = '{
    7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
    7'h03, 7'h23, 7'h13, 7'h33, 7'h73,
    7'h43, 7'h47, 7'h4B, 7'h4F, 7'h5B
  };

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0] out_rs1, out_rs2, out_rd, out_rs3;
  logic [6:0] out_opcode, out_funct7;
  logic [2:0] out_funct3;
  logic [XLEN-1:0] out_imm;
  logic out_int_we, out_r4, out_illegal;
  logic wb_valid, flush;
  logic [4:0] wb_addr;

  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_instr;
  logic [4:0] s_rs1, s_rs2, s_rd, s_rs3;
  logic [6:0] s_opcode, s_funct7;
  logic [2:0] s_funct3;
  logic [XLEN-1:0] s_imm;
  logic s_int_we, s_r4, s_illegal;
  logic s_wb_valid, s_flush;
  logic [4:0] s_wb_addr;

  always #5 clk = ~clk;

  decode_stage #(.NREG(32), .XLEN(XLEN)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_rs3(out_rs3),
    .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm),
    .out_int_we(out_int_we), .out_r4(out_r4),
    .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush)
  );

  decode_stage #(.NREG(16), .XLEN(XLEN)) u_dut16 (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_rs1(s_rs1), .out_rs2(s_rs2),
    .out_rd(s_rd), .out_rs3(s_rs3),
    .out_opcode(s_opcode), .out_funct3(s_funct3),
    .out_funct7(s_funct7), .out_imm(s_imm),
    .out_int_we(s_int_we), .out_r4(s_r4),
    .out_illegal(s_illegal),
    .wb_valid(s_wb_valid), .wb_addr(s_wb_addr),
    .flush(s_flush)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        legal;
    logic        we;
    logic        r4;
    logic        use1;
    logic        use2;
    logic [31:0] imm;
  } ref_t;

  logic        m_valid;
  logic [31:0] m_instr;
  ref_t        m_ref;
  logic [31:0] m_busy;

  function automatic ref_t ref_dec(input logic [31:0] ins,
                                   input int nreg);
    ref_t r;
    logic [31:0] sgn;
    r = '0;
    r.legal = 1'b1;
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ins[6:0])
      7'h37, 7'h17: begin
        r.we = 1'b1;
        r.imm = ins & 32'hFFFF_F000;
      end
      7'h6F: begin
        r.we = 1'b1;
        r.imm = (sgn << 20) | (ins & 32'h000F_F000)
              | (((ins >> 20) & 32'h1) << 11)
              | (((ins >> 21) & 32'h3FF) << 1);
      end
      7'h67, 7'h03, 7'h13: begin
        r.we = 1'b1;
        r.use1 = 1'b1;
        r.imm = (sgn << 12) | ((ins >> 20) & 32'hFFF);
      end
      7'h73: begin
        r.use1 = 1'b1;
        r.imm = (sgn << 12) | ((ins >> 20) & 32'hFFF);
      end
      7'h63: begin
        r.use1 = 1'b1;
        r.use2 = 1'b1;
        r.imm = (sgn << 12)
              | (((ins >> 7) & 32'h1) << 11)
              | (((ins >> 25) & 32'h3F) << 5)
              | (((ins >> 8) & 32'hF) << 1);
      end
      7'h23: begin
        r.use1 = 1'b1;
        r.use2 = 1'b1;
        r.imm = (sgn << 12)
              | (((ins >> 25) & 32'h7F) << 5)
              | ((ins >> 7) & 32'h1F);
      end
      7'h33: begin
        r.we = 1'b1;
        r.use1 = 1'b1;
        r.use2 = 1'b1;
      end
      7'h43, 7'h47, 7'h4B, 7'h4F: begin
        if (R4_EN) r.r4 = 1'b1;
        else r.legal = 1'b0;
      end
      default: r.legal = 1'b0;
    endcase
    if (r.use1 && int'(ins[19:15]) >= nreg) r.legal = 1'b0;
    if (r.use2 && int'(ins[24:20]) >= nreg) r.legal = 1'b0;
    if (r.we && int'(ins[11:7]) >= nreg) r.legal = 1'b0;
    return r;
  endfunction

  function automatic logic eff_busy(input logic [4:0] i);
    return m_busy[i] && !(wb_valid && wb_addr == i);
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("busy", 64'(u_dut.busy_q), 64'(m_busy));
    if (m_valid) begin
      check("rs1", 64'(out_rs1), 64'(m_instr[19:15]));
      check("rs2", 64'(out_rs2), 64'(m_instr[24:20]));
      check("rd", 64'(out_rd), 64'(m_instr[11:7]));
      check("rs3", 64'(out_rs3), 64'(m_instr[31:27]));
      check("opcode", 64'(out_opcode), 64'(m_instr[6:0]));
      check("funct3", 64'(out_funct3), 64'(m_instr[14:12]));
      check("funct7", 64'(out_funct7), 64'(m_instr[31:25]));
      check("imm", 64'(out_imm), 64'(m_ref.imm));
      check("int_we", 64'(out_int_we),
            64'(m_ref.we && m_ref.legal && m_instr[11:7] != 0));
      check("r4", 64'(out_r4), 64'(m_ref.r4));
      check("illegal", 64'(out_illegal), 64'(!m_ref.legal));
    end
  endtask

  task automatic step();
    ref_t r;
    logic hz, rdy, acc;
    #1;
    r = ref_dec(in_instr, 32);
    hz = (r.use1 && eff_busy(in_instr[19:15]))
      || (r.use2 && eff_busy(in_instr[24:20]))
      || (r.we && eff_busy(in_instr[11:7]));
    rdy = (!m_valid || out_ready) && !hz && !flush;
    check("in_ready", 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy;
    @(posedge clk);
    #1;
    if (flush) begin
      m_valid = 1'b0;
      m_busy = '0;
    end else begin
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (acc) begin
        m_valid = 1'b1;
        m_instr = in_instr;
        m_ref = r;
        if (r.we && r.legal && in_instr[11:7] != 0)
          m_busy[in_instr[11:7]] = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] x;
    x = $urandom;
    x[6:0] = OPS[$urandom_range(0, 14)];
    if ($urandom_range(0, 3) != 0) begin
      x[11:7]  = 5'($urandom_range(0, 7));
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
    end
    return x;
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    s_in_valid = 1'b0; s_in_instr = '0; s_out_ready = 1'b1;
    s_wb_valid = 1'b0; s_wb_addr = '0; s_flush = 1'b0;
    m_valid = 1'b0; m_instr = '0; m_ref = '0; m_busy = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_rd", 64'(out_rd), 64'(0));
    check("rst_imm", 64'(out_imm), 64'(0));
    check("rst_busy", 64'(u_dut.busy_q), 64'(0));
    reset = 1'b1;

    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF0_0293;
    step();
    check("addi_rd", 64'(out_rd), 64'(5));
    check("addi_imm", 64'(out_imm), 64'(32'hFFFF_FFFF));
    check("addi_we", 64'(out_int_we), 64'(1));
    check("addi_busy5", 64'(u_dut.busy_q[5]), 64'(1));

    in_instr = 32'h0052_8333;
    repeat (2) begin
      #1 check("raw_stall", 64'(in_ready), 64'(0));
      step();
    end
    wb_valid = 1'b1; wb_addr = 5'd5;
    #1 check("raw_wb_ready", 64'(in_ready), 64'(1));
    step();
    check("raw_acc_rd", 64'(out_rd), 64'(6));
    wb_valid = 1'b0;

    out_ready = 1'b0;
    in_instr = 32'h0030_0393;
    repeat (3) begin
      #1 check("bp_ready", 64'(in_ready), 64'(0));
      step();
      check("bp_hold_rd", 64'(out_rd), 64'(6));
    end
    out_ready = 1'b1;
    step();
    check("bp_acc_rd", 64'(out_rd), 64'(7));

    in_instr = 32'hFFF0_0293;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_flush_busy5", 64'(u_dut.busy_q[5]), 64'(1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_busy", 64'(u_dut.busy_q), 64'(0));

    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h18A5_F043;
    step();
    check("r4_flag", 64'(out_r4), 64'(R4_EN));
    check("r4_rs3", 64'(out_rs3), 64'(3));
    check("r4_illegal", 64'(out_illegal), 64'(!R4_EN));

    in_valid = 1'b0;
    s_in_valid = 1'b1;
    s_in_instr = 32'h0010_0893;
    step();
    check("n16_rd_illegal", 64'(s_illegal), 64'(1));
    check("n16_rd_we", 64'(s_int_we), 64'(0));
    check("n16_rd_busy", 64'(u_dut16.busy_q), 64'(0));
    s_in_instr = 32'h001A_0193;
    step();
    check("n16_rs1_illegal", 64'(s_illegal), 64'(1));
    s_in_instr = 32'hFFF0_0293;
    step();
    check("n16_ok_illegal", 64'(s_illegal), 64'(0));
    check("n16_ok_busy", 64'(u_dut16.busy_q), 64'(16'h0020));
    s_in_valid = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      out_ready = ($urandom_range(0, 9) < 7);
      wb_valid  = ($urandom_range(0, 9) < 3);
      wb_addr   = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end

    in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'hFFF0_0293;
    step();
    in_instr = 32'h0052_8333;
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(u_dut.busy_q), 64'(0));
    check("mid_rst_ready", 64'(in_ready), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
